// File: rtl/reg_scan_reader.sv
// Snapshots a WIDTH-bit register value and streams it LSB first over a valid/ready serial link.
// Optional feature: define SCAN_PARITY_EN to append an even-parity bit after the data bits.
module reg_scan_reader #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             CAPTURE,
   input  logic [WIDTH-1:0] D,
   output logic             SOUT,
   output logic             SVALID,
   input  logic             SREADY,
   output logic             BUSY,
   output logic             DONE
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SCAN_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_FIN} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN} state_t;
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
`ifdef SCAN_PARITY_EN
   logic             par;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (CAPTURE) state_nxt = S_SHIFT;
         S_SHIFT: if (SREADY && cnt == LAST) begin
`ifdef SCAN_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_FIN;
`endif
         end
`ifdef SCAN_PARITY_EN
         S_PARITY: if (SREADY) state_nxt = S_FIN;
`endif
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Snapshot only on the capture edge; a stalled beat leaves the shifter untouched.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         shreg <= '0;
         cnt   <= '0;
`ifdef SCAN_PARITY_EN
         par   <= 1'b0;
`endif
      end else if (state == S_IDLE && CAPTURE) begin
         shreg <= D;
         cnt   <= '0;
`ifdef SCAN_PARITY_EN
         par   <= ^D;
`endif
      end else if (state == S_SHIFT && SREADY) begin
         shreg <= shreg >> 1;
         cnt   <= cnt + CW'(1);
      end
   end

   always_comb begin
      SOUT   = 1'b0;
      SVALID = 1'b0;
      BUSY   = 1'b0;
      DONE   = 1'b0;
      case (state)
         S_SHIFT: begin
            SOUT   = shreg[0];
            SVALID = 1'b1;
            BUSY   = 1'b1;
         end
`ifdef SCAN_PARITY_EN
         S_PARITY: begin
            SOUT   = par;
            SVALID = 1'b1;
            BUSY   = 1'b1;
         end
`endif
         S_FIN:   DONE = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reg_scan_reader.sv
// Directed bench for reg_scan_reader: reset, frames, backpressure, capture isolation, mid-frame reset, parity.
module tb_reg_scan_reader;

   localparam int WIDTH = 8;
`ifdef SCAN_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif

   logic             CLK = 1'b0;
   logic             nRST = 1'b0;
   logic             CAPTURE = 1'b0;
   logic [WIDTH-1:0] D = '0;
   logic             SOUT, SVALID, BUSY, DONE;
   logic             SREADY = 1'b1;

   int n_chk = 0;
   int n_err = 0;

   reg_scan_reader #(.WIDTH(WIDTH)) dut (
      .CLK(CLK), .nRST(nRST), .CAPTURE(CAPTURE), .D(D),
      .SOUT(SOUT), .SVALID(SVALID), .SREADY(SREADY), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse CAPTURE for one edge; returns at the negedge after it, where bit 0 must be valid.
   task automatic start(input logic [WIDTH-1:0] d);
      @(negedge CLK);
      D = d;
      CAPTURE = 1'b1;
      @(negedge CLK);
      CAPTURE = 1'b0;
      chk("lat_svalid", SVALID, 1);
      chk("lat_sout", SOUT, d[0]);
   endtask

   // Consume one frame starting at a negedge with the frame active. bp selects the
   // 1,0,0,1,0,1 ready pattern; cap_beat re-pulses CAPTURE with D=0 once that many beats are done.
   task automatic run_frame(input logic [WIDTH-1:0] d, input bit bp, input int cap_beat);
      bit   pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int   nb = 0;
      int   cyc = 0;
      bit   prev_stall = 1'b0;
      logic ps = 1'b0;
      logic expb;
      while (nb < NB && cyc < 200) begin
         SREADY = bp ? pat[cyc % 6] : 1'b1;
         CAPTURE = (nb == cap_beat);
         if (CAPTURE) D = '0;
         if (prev_stall) begin
            chk("hold_sout", SOUT, ps);
            chk("hold_svalid", SVALID, 1);
         end
         chk("busy", BUSY, 1);
         chk("svalid", SVALID, 1);
         chk("done_mid", DONE, 0);
         if (SREADY) begin
            expb = (nb < WIDTH) ? d[nb] : ^d;
            chk($sformatf("bit%0d", nb), SOUT, expb);
            nb++;
         end
         prev_stall = !SREADY;
         ps = SOUT;
         cyc++;
         @(negedge CLK);
      end
      CAPTURE = 1'b0;
      SREADY = 1'b1;
      if (nb < NB) chk("frame_timeout", nb, NB);
      chk("fin_done", DONE, 1);
      chk("fin_busy", BUSY, 0);
      chk("fin_svalid", SVALID, 0);
      @(negedge CLK);
      chk("done_pulse", DONE, 0);
      chk("idle_svalid", SVALID, 0);
      chk("idle_busy", BUSY, 0);
   endtask

   initial begin
      // Reset held with CAPTURE active must keep everything quiet.
      CAPTURE = 1'b1;
      D = 8'hFF;
      repeat (2) begin
         @(negedge CLK);
         chk("rst_sout", SOUT, 0);
         chk("rst_svalid", SVALID, 0);
         chk("rst_busy", BUSY, 0);
         chk("rst_done", DONE, 0);
      end
      CAPTURE = 1'b0;
      nRST = 1'b1;
      @(negedge CLK);
      chk("post_rst_svalid", SVALID, 0);

      // Basic frame
      start(8'hA5);
      run_frame(8'hA5, 1'b0, -1);

      // Backpressure
      start(8'h3C);
      run_frame(8'h3C, 1'b1, -1);

      // Capture during a frame is ignored and not queued
      start(8'hFF);
      run_frame(8'hFF, 1'b0, 2);
      repeat (3) begin
         @(negedge CLK);
         chk("no_second_frame", SVALID, 0);
         chk("no_second_done", DONE, 0);
      end

      // Mid-frame reset
      start(8'hA5);
      SREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk($sformatf("mr_bit%0d", i + 1), SOUT, (8'hA5 >> (i + 1)) & 1);
      end
      nRST = 1'b0;
      #1;
      chk("mr_svalid", SVALID, 0);
      chk("mr_busy", BUSY, 0);
      chk("mr_sout", SOUT, 0);
      chk("mr_done", DONE, 0);
      @(negedge CLK);
      chk("mr_done_hold", DONE, 0);
      nRST = 1'b1;
      start(8'h01);
      run_frame(8'h01, 1'b0, -1);

      // Parity-sensitive values (last bit checked only when parity is built in)
      start(8'h07);
      run_frame(8'h07, 1'b0, -1);
      start(8'h03);
      run_frame(8'h03, 1'b1, -1);

      // CAPTURE held through FIN starts the next frame right after one idle cycle
      start(8'h5A);
      SREADY = 1'b1;
      for (int i = 1; i < NB; i++) @(negedge CLK);
      CAPTURE = 1'b1;
      D = 8'hC3;
      @(negedge CLK);
      chk("b2b_fin_done", DONE, 1);
      @(negedge CLK);
      chk("b2b_idle_svalid", SVALID, 0);
      @(negedge CLK);
      CAPTURE = 1'b0;
      chk("b2b_restart_svalid", SVALID, 1);
      chk("b2b_restart_sout", SOUT, 1);
      run_frame(8'hC3, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
